// File: rtl/sum4_pkg.sv
// Shared types, default widths and the round-robin owner search for the
// sum4 scheduler.
package sum4_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int unsigned DEF_DW  = 14;
    localparam int unsigned DEF_OW  = 17;
    localparam int unsigned DEF_IDW = 2;
    localparam int unsigned MAX_REQ = 4;

    // First asserted requester at or above ptr, wrapping modulo nreq.
    function automatic logic [1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [1:0]         ptr,
                                           input int unsigned        nreq);
        logic [1:0] pick;
        logic [1:0] cand;
        logic       found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            cand = 2'((32'(ptr) + i) % nreq);
            if (!found && (i < nreq) && valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sum4_pipe.sv
// Two-stage 4-operand adder carrying valid/ID/last alongside the data.
// Data fields only load with a valid beat so results hold between strobes.
module sum4_pipe
    import sum4_pkg::*;
#(
    parameter int unsigned DW  = DEF_DW,
    parameter int unsigned OW  = DEF_OW,
    parameter int unsigned IDW = DEF_IDW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [IDW-1:0]  in_id,
    input  logic            in_last,
    input  logic [4*DW-1:0] in_ops,
    output logic            out_valid,
    output logic [IDW-1:0]  out_id,
    output logic            out_last,
    output logic [OW-1:0]   out_sum,
    output logic            busy
);

    logic           v1_q;
    logic [IDW-1:0] id1_q;
    logic           last1_q;
    logic [DW:0]    p0_q;
    logic [DW:0]    p1_q;

    logic           v2_q;
    logic [IDW-1:0] id2_q;
    logic           last2_q;
    logic [OW-1:0]  sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            id1_q   <= '0;
            last1_q <= 1'b0;
            p0_q    <= '0;
            p1_q    <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                id1_q   <= in_id;
                last1_q <= in_last;
                p0_q    <= (DW+1)'(in_ops[0*DW +: DW]) + (DW+1)'(in_ops[1*DW +: DW]);
                p1_q    <= (DW+1)'(in_ops[2*DW +: DW]) + (DW+1)'(in_ops[3*DW +: DW]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q    <= 1'b0;
            id2_q   <= '0;
            last2_q <= 1'b0;
            sum_q   <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                id2_q   <= id1_q;
                last2_q <= last1_q;
                sum_q   <= OW'((DW+2)'(p0_q) + (DW+2)'(p1_q));
            end
        end
    end

    assign out_valid = v2_q;
    assign out_id    = id2_q;
    assign out_last  = last2_q;
    assign out_sum   = sum_q;
    assign busy      = v1_q | v2_q;

endmodule

// File: rtl/sum4_sched.sv
// Round-robin burst scheduler in front of a shared 2-stage 4-operand adder;
// one requester owns the adder for a whole burst.
module sum4_sched
    import sum4_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned OW   = DEF_OW,
    parameter int unsigned IDW  = DEF_IDW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_last,
    input  logic [NREQ*4*DW-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic                 res_last,
    output logic [OW-1:0]        res_sum,
    output logic                 busy
);

    state_t             state_q, state_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic               own_valid;
    logic               own_last;
    logic [4*DW-1:0]    own_ops;
    logic               accept;
    logic               pipe_busy;
    logic [MAX_REQ-1:0] valid_ext;

    assign valid_ext = MAX_REQ'(req_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_ops   = '0;
        for (int unsigned r = 0; r < NREQ; r++) begin
            if (owner_q == IDW'(r)) begin
                own_valid = req_valid[r];
                own_last  = req_last[r];
                own_ops   = req_data[r*4*DW +: 4*DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    owner_d = IDW'(rr_pick(valid_ext, 2'(rr_ptr_q), NREQ));
                    state_d = OWN;
                end
            end
            OWN: begin
                for (int unsigned r = 0; r < NREQ; r++) begin
                    req_ready[r] = (owner_q == IDW'(r));
                end
                accept = own_valid;
                // The pointer moves past the owner only when its burst closes.
                if (own_valid && own_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == IDW'(NREQ-1)) ? '0 : owner_q + IDW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sum4_pipe #(
        .DW (DW),
        .OW (OW),
        .IDW(IDW)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept),
        .in_id    (owner_q),
        .in_last  (own_last),
        .in_ops   (own_ops),
        .out_valid(res_valid),
        .out_id   (res_id),
        .out_last (res_last),
        .out_sum  (res_sum),
        .busy     (pipe_busy)
    );

    assign busy = (state_q == OWN) | pipe_busy;

endmodule
